// File: rtl/lcd_text_buffer_pkg.sv
// Shared constants, FSM encoding and write payload for the LCD text shadow buffer.
package lcd_text_buffer_pkg;

  localparam int unsigned LCD_COLS  = 16;
  localparam int unsigned LCD_LINES = 2;
  localparam int unsigned LCD_CELLS = LCD_COLS * LCD_LINES;
  localparam int unsigned ADDR_W    = $clog2(LCD_CELLS);
  localparam int unsigned CHAR_W    = 8;
  localparam int unsigned CNT_W     = 3;

  localparam logic [CHAR_W-1:0] ASCII_SPACE = 8'h20;

  typedef enum logic [1:0] {
    SCAN      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } lcd_state_e;

  // One character transfer towards the controller.
  typedef struct packed {
    logic [ADDR_W-1:0] pos;
    logic [CHAR_W-1:0] data;
  } lcd_cell_t;

  // Scan order is plain ascending with wrap from the last cell back to 0.
  function automatic logic [ADDR_W-1:0] next_cell(input logic [ADDR_W-1:0] p);
    return p + ADDR_W'(1);
  endfunction

endpackage

// File: rtl/lcd_text_buffer_if.sv
// Host write port plus lcd_controller handshake of the text shadow buffer.
interface lcd_text_buffer_if;
  import lcd_text_buffer_pkg::*;

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [CHAR_W-1:0] wr_data;
  logic              clr;
  logic              lcd_ready;
  logic [CHAR_W-1:0] char_data;
  logic [ADDR_W-1:0] cursor_pos;
  logic              write_enable;
  logic              clean;

  // Host and controller side together.
  modport master (
    output wr_en, wr_addr, wr_data, clr, lcd_ready,
    input  char_data, cursor_pos, write_enable, clean
  );

  // The buffer itself.
  modport slave (
    input  wr_en, wr_addr, wr_data, clr, lcd_ready,
    output char_data, cursor_pos, write_enable, clean
  );

endinterface

// File: rtl/lcd_text_buffer.sv
// 2x16 shadow frame buffer: host writes mark cells dirty, a refresh engine
// pushes each dirty cell to lcd_controller under its ready handshake.
module lcd_text_buffer
  import lcd_text_buffer_pkg::*;
#(
  parameter logic [CHAR_W-1:0] BLANK_CHAR = ASCII_SPACE,
  parameter int unsigned       BUSY_WAIT  = 4
) (
  input logic               clk,
  input logic               rst,
  lcd_text_buffer_if.slave  bus
);

  lcd_state_e             state_q, state_d;
  logic [ADDR_W-1:0]      ptr_q, ptr_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [LCD_CELLS-1:0]   dirty_q, dirty_d;
  logic [CHAR_W-1:0]      mem_q [0:LCD_CELLS-1];
  lcd_cell_t              cell_q, cell_d;
  logic                   we_q, we_d;
  logic                   clean_q, clean_d;
  logic                   take;

  // Refresh FSM: next state, scan pointer, busy-wait counter and output latch.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    cell_d  = cell_q;
    take    = 1'b0;
    case (state_q)
      SCAN: begin
        if (dirty_q[ptr_q]) begin
          if (bus.lcd_ready) begin
            cell_d.pos  = ptr_q;
            cell_d.data = mem_q[ptr_q];
            take        = 1'b1;
            state_d     = ISSUE;
          end
        end else begin
          ptr_d = next_cell(ptr_q);
        end
      end
      ISSUE: begin
        cnt_d   = CNT_W'(BUSY_WAIT);
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        // A controller that never drops ready is released after BUSY_WAIT cycles.
        if (!bus.lcd_ready) begin
          state_d = WAIT_DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q <= CNT_W'(1)) begin
            state_d = WAIT_DONE;
          end
        end
      end
      WAIT_DONE: begin
        if (bus.lcd_ready) begin
          ptr_d   = next_cell(ptr_q);
          state_d = SCAN;
        end
      end
      default: state_d = SCAN;
    endcase
    we_d    = (state_d == ISSUE);
    clean_d = (dirty_q == '0) && (state_q == SCAN);
  end

  // Dirty tracking: host set (write or clear) overrides the scanner's clear.
  always_comb begin
    dirty_d = dirty_q;
    if (take) begin
      dirty_d[ptr_q] = 1'b0;
    end
    if (bus.clr) begin
      dirty_d = '1;
    end
    if (bus.wr_en) begin
      dirty_d[bus.wr_addr] = 1'b1;
    end
  end

  // Control and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SCAN;
      ptr_q   <= '0;
      cnt_q   <= '0;
      dirty_q <= '1;
      cell_q  <= '0;
      we_q    <= 1'b0;
      clean_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      dirty_q <= dirty_d;
      cell_q  <= cell_d;
      we_q    <= we_d;
      clean_q <= clean_d;
    end
  end

  // Character store: clear first, then a same-cycle write lands on top.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(LCD_CELLS); i++) begin
        mem_q[i] <= BLANK_CHAR;
      end
    end else begin
      if (bus.clr) begin
        for (int i = 0; i < int'(LCD_CELLS); i++) begin
          mem_q[i] <= BLANK_CHAR;
        end
      end
      if (bus.wr_en) begin
        mem_q[bus.wr_addr] <= bus.wr_data;
      end
    end
  end

  assign bus.char_data    = cell_q.data;
  assign bus.cursor_pos   = cell_q.pos;
  assign bus.write_enable = we_q;
  assign bus.clean        = clean_q;

endmodule
